// File: rtl/risc_operand_fetch.sv
// risc_operand_fetch
// Register file and operand-fetch stage. Holds NREG x 32-bit registers
// (R0 reads as zero) and a per-register pending-write counter. Issue is
// stalled on RAW hazards against outstanding writes, and when a destination
// counter would overflow. Accepted instructions get their A/B operands
// registered one cycle later.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   issue_valid         : decode presents an instruction
//   issue_ready         : combinational accept qualifier (independent of issue_valid)
//   AA, BA              : source register addresses
//   RW_0, DA_0          : issued instruction writes register DA_0
//   RW_1, DA_1, Bus_D   : write-back enable, destination and data
//   Bus_A, Bus_B        : registered operands
//   op_valid            : Bus_A/Bus_B belong to an instruction accepted last cycle
//   wb_err              : sticky, a write-back hit a register with no pending write
//
// Configuration macro
//   RISC_RF_BYPASS_EN   : when defined, write-back data is forwarded into the
//                         operand capture and a source with exactly one pending
//                         write that is being written this cycle does not stall.

module risc_operand_fetch #(
    parameter int NREG   = 32,
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  AA,
    input  logic [4:0]  BA,
    input  logic        RW_0,
    input  logic [4:0]  DA_0,
    input  logic        RW_1,
    input  logic [4:0]  DA_1,
    input  logic [31:0] Bus_D,
    output logic [31:0] Bus_A,
    output logic [31:0] Bus_B,
    output logic        op_valid,
    output logic        wb_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [31:0]       regFile_q [NREG];
    logic [PEND_W-1:0] pend_q    [NREG];
    logic [PEND_W-1:0] pend_d    [NREG];
    logic [31:0]       busA_q, busA_d;
    logic [31:0]       busB_q, busB_d;
    logic              opValid_q;
    logic              wbErr_q, wbErr_d;

    logic wbHit;
    logic accept;
    logic destFull;

    // Addresses beyond NREG (only possible with a reduced NREG) behave like
    // R0: never pending, read as zero, writes dropped.
    function automatic logic inRange(input logic [4:0] a);
        return (int'(a) < NREG);
    endfunction

    function automatic logic [PEND_W-1:0] pendAt(input logic [4:0] a);
        logic [PEND_W-1:0] p;
        p = '0;
        if (a != 5'd0 && inRange(a)) begin
            p = pend_q[a];
        end
        return p;
    endfunction

    function automatic logic srcReady(input logic [4:0] a);
        logic ok;
        ok = (a == 5'd0) || (pendAt(a) == '0);
`ifdef RISC_RF_BYPASS_EN
        if (pendAt(a) == PEND_ONE && wbHit && DA_1 == a) begin
            ok = 1'b1;
        end
`endif
        return ok;
    endfunction

    function automatic logic [31:0] opValue(input logic [4:0] a);
        logic [31:0] v;
        v = '0;
        if (a != 5'd0 && inRange(a)) begin
            v = regFile_q[a];
`ifdef RISC_RF_BYPASS_EN
            if (wbHit && DA_1 == a) begin
                v = Bus_D;
            end
`endif
        end
        return v;
    endfunction

    assign wbHit = RW_1 && (DA_1 != 5'd0) && inRange(DA_1);

    // A destination whose counter is already saturated can only be issued
    // again if one of its outstanding writes retires in the same cycle.
    assign destFull = RW_0 && (DA_0 != 5'd0) && (pendAt(DA_0) == PEND_MAX) &&
                      !(wbHit && DA_1 == DA_0);

    assign issue_ready = srcReady(AA) && srcReady(BA) && !destFull;
    assign accept      = issue_valid && issue_ready;

    // Scoreboard next state: an issue and a retire on the same register
    // cancel; a retire on an empty counter leaves it at zero.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic inc;
            logic dec;
            pend_d[r] = pend_q[r];
            inc = accept && RW_0 && (DA_0 == 5'(r));
            dec = wbHit && (DA_1 == 5'(r));
            if (r == 0) begin
                pend_d[r] = '0;
            end else if (inc && !dec) begin
                pend_d[r] = pend_q[r] + PEND_ONE;
            end else if (dec && !inc && pend_q[r] != '0) begin
                pend_d[r] = pend_q[r] - PEND_ONE;
            end
        end
    end

    // Operand capture and the unexpected write-back flag.
    always_comb begin
        busA_d  = busA_q;
        busB_d  = busB_q;
        wbErr_d = wbErr_q;
        if (accept) begin
            busA_d = opValue(AA);
            busB_d = opValue(BA);
        end
        if (wbHit && pendAt(DA_1) == '0) begin
            wbErr_d = 1'b1;
        end
    end

    // All state, including the register file, clears on reset so that
    // operands read before any write-back are deterministic zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regFile_q[r] <= '0;
                pend_q[r]    <= '0;
            end
            busA_q    <= '0;
            busB_q    <= '0;
            opValid_q <= 1'b0;
            wbErr_q   <= 1'b0;
        end else begin
            if (wbHit) begin
                regFile_q[DA_1] <= Bus_D;
            end
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
            busA_q    <= busA_d;
            busB_q    <= busB_d;
            opValid_q <= accept;
            wbErr_q   <= wbErr_d;
        end
    end

    assign Bus_A    = busA_q;
    assign Bus_B    = busB_q;
    assign op_valid = opValid_q;
    assign wb_err   = wbErr_q;

endmodule

// File: tb/tb_risc_operand_fetch.sv
// Testbench for risc_operand_fetch: directed vectors with literal expectations
// plus a behavioural model compared against the DUT on every cycle.

module tb_risc_operand_fetch;

`ifdef RISC_RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int MAXP = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        issueValid;
   logic        issueReady;
   logic [4:0]  aa, ba, da0, da1;
   logic        rw0, rw1;
   logic [31:0] busD;
   logic [31:0] busA, busB;
   logic        opValid;
   logic        wbErr;

   int checkCount = 0;
   int passCount  = 0;
   bit started    = 1'b0;
   logic lastReady;

   // Behavioural model state
   logic [31:0] mReg [32];
   int          mPend [32];
   logic [31:0] mA, mB;
   logic        mOpv, mErr;
   logic        mAcc, mWb, mInc;
   logic [31:0] mNextA, mNextB;

   risc_operand_fetch dut (
      .clk(clk),
      .reset(reset),
      .issue_valid(issueValid),
      .issue_ready(issueReady),
      .AA(aa),
      .BA(ba),
      .RW_0(rw0),
      .DA_0(da0),
      .RW_1(rw1),
      .DA_1(da1),
      .Bus_D(busD),
      .Bus_A(busA),
      .Bus_B(busB),
      .op_valid(opValid),
      .wb_err(wbErr)
   );

   always #5 clk = ~clk;

   // Safety net against a stuck run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Source s is free if R0, nothing pending, or (bypass) its single
   // pending write lands this cycle.
   function automatic bit srcOk(input int s);
      return (s == 0) || (mPend[s] == 0) ||
             (BYP && mPend[s] == 1 && rw1 && int'(da1) == s);
   endfunction

   function automatic bit modelReady();
      bit full;
      full = rw0 && da0 != 0 && mPend[da0] == MAXP && !(rw1 && da1 == da0);
      return srcOk(int'(aa)) && srcOk(int'(ba)) && !full;
   endfunction

   function automatic logic [31:0] modelValue(input int s);
      if (s == 0) return 32'h0;
      if (BYP && rw1 && int'(da1) == s) return busD;
      return mReg[s];
   endfunction

   // Model advances on each rising edge from the inputs held during the cycle
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            mReg[i]  = 32'h0;
            mPend[i] = 0;
         end
         mA = 0; mB = 0; mOpv = 0; mErr = 0;
      end else begin
         mAcc   = issueValid && modelReady();
         mNextA = modelValue(int'(aa));
         mNextB = modelValue(int'(ba));
         if (mAcc) begin
            mA = mNextA;
            mB = mNextB;
         end
         mOpv = mAcc;
         mWb  = rw1 && da1 != 0;
         mInc = mAcc && rw0 && da0 != 0;
         if (mWb && mPend[da1] == 0) mErr = 1'b1;
         if (!(mInc && mWb && da0 == da1)) begin
            if (mInc) mPend[da0] = mPend[da0] + 1;
            if (mWb && mPend[da1] > 0) mPend[da1] = mPend[da1] - 1;
         end
         if (mWb) mReg[da1] = busD;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (started) begin
         checkOutput("issue_ready", {31'b0, issueReady}, {31'b0, modelReady()});
         checkOutput("Bus_A", busA, mA);
         checkOutput("Bus_B", busB, mB);
         checkOutput("op_valid", {31'b0, opValid}, {31'b0, mOpv});
         checkOutput("wb_err", {31'b0, wbErr}, {31'b0, mErr});
      end
   end

   // Drive one cycle of inputs, capture issue_ready mid-cycle, and return
   // just after the edge that consumed them.
   task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [4:0] b,
                                input logic w0, input logic [4:0] d0,
                                input logic w1, input logic [4:0] d1, input logic [31:0] data);
      issueValid = v; aa = a; ba = b; rw0 = w0; da0 = d0; rw1 = w1; da1 = d1; busD = data;
      @(negedge clk);
      lastReady = issueReady;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      issueValid = 0; aa = 0; ba = 0; rw0 = 0; da0 = 0; rw1 = 0; da1 = 0; busD = 0;
      @(posedge clk); #1;
      started = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Reset and R0
      applyStimulus(1, 0, 5, 0, 0, 0, 0, 32'h0);
      checkOutput("ready_after_reset", {31'b0, lastReady}, 32'd1);
      checkOutput("r0_busA", busA, 32'h0);
      checkOutput("r5_busB", busB, 32'h0);
      checkOutput("first_op_valid", {31'b0, opValid}, 32'd1);
      checkOutput("no_err_after_reset", {31'b0, wbErr}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'hDEAD);
      checkOutput("idle_op_valid", {31'b0, opValid}, 32'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("r0_after_write", busA, 32'h0);

      // RAW stall on R3
      applyStimulus(1, 0, 0, 1, 3, 0, 0, 32'h0);
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("raw_stall", {31'b0, lastReady}, 32'd0);
      checkOutput("raw_stall_op_valid", {31'b0, opValid}, 32'd0);
      applyStimulus(1, 3, 0, 0, 0, 1, 3, 32'h1234);
`ifdef RISC_RF_BYPASS_EN
      checkOutput("raw_bypass_ready", {31'b0, lastReady}, 32'd1);
      checkOutput("raw_bypass_busA", busA, 32'h1234);
`else
      checkOutput("raw_wb_cycle_stall", {31'b0, lastReady}, 32'd0);
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("raw_release_ready", {31'b0, lastReady}, 32'd1);
      checkOutput("raw_release_busA", busA, 32'h1234);
`endif

      // Counter saturation on R7
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 1, 7, 0, 0, 32'h0);
         checkOutput("sat_fill_ready", {31'b0, lastReady}, 32'd1);
      end
      applyStimulus(1, 0, 0, 1, 7, 0, 0, 32'h0);
      checkOutput("sat_full_stall", {31'b0, lastReady}, 32'd0);
      applyStimulus(1, 0, 0, 1, 7, 1, 7, 32'h77);
      checkOutput("sat_with_wb_ready", {31'b0, lastReady}, 32'd1);
      checkOutput("model_pend7", mPend[7], 32'd3);
      applyStimulus(1, 0, 0, 1, 7, 0, 0, 32'h0);
      checkOutput("sat_still_full", {31'b0, lastReady}, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'h70 + i);
      checkOutput("sat_drain_no_err", {31'b0, wbErr}, 32'd0);
      applyStimulus(1, 7, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("sat_last_value", busA, 32'h72);

      // Simultaneous issue and write-back to R9
      applyStimulus(1, 0, 0, 1, 9, 0, 0, 32'h0);
      applyStimulus(1, 0, 0, 1, 9, 1, 9, 32'h99);
      checkOutput("same_reg_ready", {31'b0, lastReady}, 32'd1);
      applyStimulus(1, 9, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("same_reg_still_pending", {31'b0, lastReady}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 1, 9, 32'h55);
      checkOutput("same_reg_no_err", {31'b0, wbErr}, 32'd0);

      // Unexpected write-back to R12
      applyStimulus(0, 0, 0, 0, 0, 1, 12, 32'hA5);
      checkOutput("unexpected_err", {31'b0, wbErr}, 32'd1);
      applyStimulus(1, 12, 9, 0, 0, 0, 0, 32'h0);
      checkOutput("unexpected_ready", {31'b0, lastReady}, 32'd1);
      checkOutput("unexpected_data", busA, 32'hA5);
      checkOutput("r9_data", busB, 32'h55);
      idle();
      checkOutput("err_sticky", {31'b0, wbErr}, 32'd1);

      // Reset mid-flight with two writes pending on R4
      applyStimulus(1, 0, 0, 1, 4, 0, 0, 32'h0);
      applyStimulus(1, 0, 0, 1, 4, 0, 0, 32'h0);
      checkOutput("model_pend4", mPend[4], 32'd2);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      checkOutput("midreset_busA", busA, 32'h0);
      checkOutput("midreset_busB", busB, 32'h0);
      checkOutput("midreset_err", {31'b0, wbErr}, 32'd0);
      applyStimulus(1, 4, 4, 0, 0, 0, 0, 32'h0);
      checkOutput("midreset_no_stall", {31'b0, lastReady}, 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'h44);
      checkOutput("inflight_wb_err", {31'b0, wbErr}, 32'd1);
      applyStimulus(1, 4, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("inflight_wb_data", busA, 32'h44);
      idle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/risc_operand_fetch.md
# risc_operand_fetch

Register file and operand-fetch stage that consumes the write-back bus (`Bus_D`, `DA_1`, `RW_1`) and supplies registered A/B operands to execute. It holds 32×32-bit registers and a per-register pending-write scoreboard that stalls issue on RAW hazards. It also stalls when a destination's in-flight write counter would overflow. It sits between decode (issue side) and execute, closing the loop from the write-back stage.

## Interface
Parameters
- `NREG`, 32: register count. R0 is hardwired to zero.
- `PEND_W`, 2: width of each per-register pending counter. Maximum outstanding writes per register is 2^PEND_W−1.

Ports
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `issue_valid`, input, 1: decode presents an instruction.
- `issue_ready`, output, 1: combinational. The instruction is accepted when `issue_valid && issue_ready`.
- `AA`, input, 5: source A register address.
- `BA`, input, 5: source B register address.
- `RW_0`, input, 1: the issued instruction writes a register.
- `DA_0`, input, 5: destination of the issued instruction.
- `RW_1`, input, 1: write-back enable.
- `DA_1`, input, 5: write-back destination.
- `Bus_D`, input, 32: write-back data.
- `Bus_A`, output, 32: registered operand A.
- `Bus_B`, output, 32: registered operand B.
- `op_valid`, output, 1: `Bus_A`/`Bus_B` hold the operands of an instruction accepted the previous cycle.
- `wb_err`, output, 1: sticky flag. Set when a write-back targets a register whose pending count is 0.

## Operation
- **Write:** on a rising edge with `RW_1 && DA_1!=0`, `reg[DA_1] <= Bus_D`. Writes to R0 are dropped. Reads of R0 always return 0.
- **Scoreboard:** `pend[r]` is a PEND_W-bit counter per register. `pend[0]` is always 0.
  - Increment when an accepted issue has `RW_0 && DA_0==r`.
  - Decrement when `RW_1 && DA_1==r`.
  - Both in the same cycle: counter is unchanged.
- **Unexpected write-back:** a write-back to r with `pend[r]==0` still writes the data. The counter stays 0 (no underflow) and `wb_err` is set, cleared only by `reset`.
- **Source readiness:** source s is ready when `s==0` or `pend[s]==0`. With bypass compiled in, s is also ready when `pend[s]==1 && RW_1 && DA_1==s`.
- **`issue_ready`:** true when all of the following hold:
  - source A is ready;
  - source B is ready;
  - not (`RW_0 && DA_0!=0 && pend[DA_0]==max` and no decrement of DA_0 this cycle).
- **`issue_ready` independence:** `issue_ready` does not depend on `issue_valid`.
- **Accepted issue:** `Bus_A <= value(AA)`, `Bus_B <= value(BA)`, `op_valid <= 1`. Here value() is the bypassed `Bus_D` when bypass applies, otherwise the stored register.
- **No accepted issue:** `op_valid <= 0`. `Bus_A`/`Bus_B` hold their previous values.
- **Self-dependency:** an instruction with `DA_0==AA` reads the old value. Its own increment does not stall itself.

## Timing
- **Reset values:**
  - all registers 0;
  - all `pend` 0;
  - `Bus_A=Bus_B=0`, `op_valid=0`, `wb_err=0`.
- **Ready after reset:** `issue_ready=1` in the first cycle after reset deasserts.
- **Reset mid-operation:** clears the scoreboard. Write-backs still in flight are then treated as unexpected: they write and set `wb_err`.
- **Issue-to-operand latency:** 1 cycle. An issue accepted at edge N gives `op_valid=1` and operands valid after edge N.
- **Write-to-read latency:**
  - with bypass: 0 cycles (operand captured at the same edge as the write);
  - without bypass: 1 cycle, because the stall releases the cycle after the write.
- **Combinational path:** `issue_ready` depends combinationally on `AA`, `BA`, `RW_0`, `DA_0`, `RW_1`, `DA_1`. There is no combinational path to `Bus_A`/`Bus_B`/`op_valid`.

## Configuration
- `RISC_RF_BYPASS_EN`, defined:
  - write-back data is forwarded to the operand capture in the same cycle;
  - a source with `pend==1` being written this cycle does not stall.
- `RISC_RF_BYPASS_EN`, undefined:
  - no forwarding; any source with `pend!=0` stalls;
  - a same-cycle write/read of one register captures the old value;
  - that case only arises for `pend==0`, i.e. an unexpected write-back.

## Test plan
- **Reset and R0:** assert reset 2 cycles, then issue AA=0, BA=5 → `Bus_A=0`, `Bus_B=0`, `op_valid=1` next cycle, `wb_err=0`. Then write-back R0=0xDEAD and re-read → `Bus_A=0`.
- **RAW stall:**
  - issue RW_0=1, DA_0=3 → `pend[3]=1`;
  - next issue AA=3 → `issue_ready=0`;
  - write-back DA_1=3, Bus_D=0x1234 that cycle:
    - with bypass: `issue_ready=1` and `Bus_A=0x1234` next cycle;
    - without bypass: ready the following cycle, `Bus_A=0x1234`.
- **Counter saturation:** three accepted issues with DA_0=7 → `pend[7]=3`. A fourth → `issue_ready=0`. With a concurrent write-back to R7 → ready, `pend` stays 3.
- **Simultaneous issue and write-back to the same register:** `pend[9]=1`; issue DA_0=9 while write-back DA_1=9 → `pend[9]` stays 1.
- **Unexpected write-back:** write-back DA_1=12 with `pend[12]=0`, Bus_D=0xA5 → `wb_err=1` persists. A later read of R12 returns 0xA5. `wb_err` is cleared only by reset.
- **Reset mid-flight:** `pend[4]=2`, assert reset → all `pend` 0, `Bus_A=Bus_B=0`. A subsequent issue reading R4 is not stalled.
